// File: rtl/sa_skew_feeder_if.sv
// Buffer-write, control and lane-bus signals between the skew feeder and its
// host / PE row. The host drives writes and start; the feeder drives the rest.
interface sa_skew_feeder_if #(
  parameter int N = 3,
  parameter int K = 9
);
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = (K > 1) ? $clog2(K) : 1;

  logic          wr_en;
  logic          wr_sel;
  logic [LW-1:0] wr_lane;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic          clear;
  logic [8*N-1:0] din_bus;
  logic [8*N-1:0] win_bus;

  modport master (
    output wr_en, wr_sel, wr_lane, wr_addr, wr_data, start,
    input  busy, done, clear, din_bus, win_bus
  );

  modport slave (
    input  wr_en, wr_sel, wr_lane, wr_addr, wr_data, start,
    output busy, done, clear, din_bus, win_bus
  );
endinterface

// File: rtl/sa_skew_feeder.sv
// Operand sequencer for a row of N systolic PEs. Buffers one data and one
// weight vector of length K per lane and streams them with a one-cycle-per-lane
// diagonal skew, framed by a clear pulse before and a done pulse after.
// Every output is a register loaded from the next-state decode, so nothing
// combinational reaches the PE row from the inputs.
module sa_skew_feeder #(
  parameter int N = 3,
  parameter int K = 9
) (
  input logic            clk,
  input logic            rst,
  sa_skew_feeder_if.slave bus
);
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = (K > 1) ? $clog2(K) : 1;
  localparam int CW = $clog2(K + N);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  // Last skew step: lane N-1 presents element K-1 when cnt reaches this.
  localparam logic [CW-1:0] CNT_LAST = CW'(K + N - 2);

  logic [7:0]     dmem_r [N][K];
  logic [7:0]     wmem_r [N][K];

  logic [1:0]     state_r;
  logic [1:0]     state_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_nxt_s;

  logic           busy_r;
  logic           done_r;
  logic           clear_r;
  logic [8*N-1:0] din_r;
  logic [8*N-1:0] win_r;
  logic [8*N-1:0] din_nxt_s;
  logic [8*N-1:0] win_nxt_s;

  logic           wr_ok_s;

  // A buffer write lands only while idle and only for an in-range lane/element.
  always_comb begin
    wr_ok_s = 1'b0;
    if (bus.wr_en && (state_r == ST_IDLE) &&
        (32'(bus.wr_lane) < 32'(N)) && (32'(bus.wr_addr) < 32'(K))) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Operand buffers; deliberately not reset, contents are whatever was written.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      if (bus.wr_sel) begin
        wmem_r[bus.wr_lane][bus.wr_addr] <= bus.wr_data;
      end else begin
        dmem_r[bus.wr_lane][bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  // Pass sequencing: IDLE -> CLEAR -> STREAM (cnt 0..K+N-2) -> DRAIN -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
        cnt_nxt_s = '0;
      end
      ST_CLEAR: begin
        state_nxt_s = ST_STREAM;
        cnt_nxt_s   = '0;
      end
      ST_STREAM: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DRAIN;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_STREAM;
          cnt_nxt_s   = cnt_r + CW'(1);
        end
      end
      ST_DRAIN: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Lane buses for the coming cycle: lane i shows element cnt-i while in range.
  always_comb begin
    din_nxt_s = '0;
    win_nxt_s = '0;
    if (state_nxt_s == ST_STREAM) begin
      for (int i = 0; i < N; i++) begin
        if ((32'(cnt_nxt_s) >= 32'(i)) &&
            ((32'(cnt_nxt_s) - 32'(i)) < 32'(K))) begin
          din_nxt_s[8*i +: 8] = dmem_r[i][AW'(32'(cnt_nxt_s) - 32'(i))];
          win_nxt_s[8*i +: 8] = wmem_r[i][AW'(32'(cnt_nxt_s) - 32'(i))];
        end else begin
          din_nxt_s[8*i +: 8] = 8'd0;
          win_nxt_s[8*i +: 8] = 8'd0;
        end
      end
    end else begin
      din_nxt_s = '0;
      win_nxt_s = '0;
    end
  end

  // State, counter and registered outputs; reset abandons any pass silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      clear_r <= 1'b0;
      din_r   <= '0;
      win_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DRAIN);
      clear_r <= (state_nxt_s == ST_CLEAR);
      din_r   <= din_nxt_s;
      win_r   <= win_nxt_s;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.clear   = clear_r;
  assign bus.din_bus = din_r;
  assign bus.win_bus = win_r;

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Bench for sa_skew_feeder: directed passes plus randomized buffer contents,
// checked cycle by cycle against a pass-timeline model and a PE-row model.
module tb_sa_skew_feeder;
  localparam int N  = 3;
  localparam int K  = 9;
  localparam int P  = K + N + 2;
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = (K > 1) ? $clog2(K) : 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sa_skew_feeder_if #(.N(N), .K(K)) bus ();

  sa_skew_feeder #(.N(N), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mdat [N][K];
  logic [7:0] mwt  [N][K];
  logic [7:0] acc  [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected lane bus in pass cycle c: lane i shows element c-2-i.
  function automatic logic [8*N-1:0] exp_bus(input int c, input bit wsel);
    logic [8*N-1:0] v;
    int j;
    v = '0;
    for (int i = 0; i < N; i++) begin
      j = c - 2 - i;
      if (j >= 0 && j < K) v[8*i +: 8] = wsel ? mwt[i][j] : mdat[i][j];
    end
    return v;
  endfunction

  function automatic int dot_ref(input int i);
    int s;
    s = 0;
    for (int j = 0; j < K; j++) s += int'(mdat[i][j]) * int'(mwt[i][j]);
    return s % 256;
  endfunction

  task automatic wr(input bit sel, input int lane, input int addr, input logic [7:0] val);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_lane = LW'(lane);
    bus.wr_addr = AW'(addr);
    bus.wr_data = val;
    tick();
    bus.wr_en = 1'b0;
    if (lane < N && addr < K) begin
      if (sel) mwt[lane][addr] = val;
      else     mdat[lane][addr] = val;
    end
  endtask

  // One pass starting in the current idle cycle (cycle 0). glitch_c: cycle with
  // an extra start pulse; late_c: cycle with a write of 99 to data lane0/addr0;
  // start_wr: a random in-range write alongside start.
  task automatic run_pass(input int glitch_c, input int late_c, input bit start_wr);
    int lane, addr;
    bit sel;
    logic [7:0] val;
    bus.start = 1'b1;
    if (start_wr) begin
      lane = $urandom_range(N - 1);
      addr = $urandom_range(K - 1);
      sel  = 1'($urandom_range(1));
      val  = 8'($urandom);
      bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_lane = LW'(lane);
      bus.wr_addr = AW'(addr); bus.wr_data = val;
      if (sel) mwt[lane][addr] = val;
      else     mdat[lane][addr] = val;
    end
    for (int c = 1; c < P; c++) begin
      tick();
      bus.start = (c == glitch_c);
      bus.wr_en = (c == late_c);
      if (c == late_c) begin
        bus.wr_sel = 1'b0; bus.wr_lane = '0; bus.wr_addr = '0; bus.wr_data = 8'd99;
      end
      chk($sformatf("clear c%0d", c), 32'(bus.clear), 32'(c == 1));
      chk($sformatf("busy c%0d", c), 32'(bus.busy), 32'd1);
      chk($sformatf("done c%0d", c), 32'(bus.done), 32'(c == P - 1));
      chk($sformatf("din c%0d", c), 32'(bus.din_bus), 32'(exp_bus(c, 1'b0)));
      chk($sformatf("win c%0d", c), 32'(bus.win_bus), 32'(exp_bus(c, 1'b1)));
      if (c == P - 1) begin
        for (int i = 0; i < N; i++) chk($sformatf("pe%0d", i), 32'(acc[i]), 32'(dot_ref(i)));
      end
      // PE row: clear zeroes, otherwise each cycle adds din*win mod 256.
      for (int i = 0; i < N; i++) begin
        if (bus.clear) acc[i] = 8'd0;
        else acc[i] = 8'(acc[i] + bus.din_bus[8*i +: 8] * bus.win_bus[8*i +: 8]);
      end
    end
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    chk("idle busy", 32'(bus.busy), 32'd0);
    chk("idle done", 32'(bus.done), 32'd0);
    chk("idle din", 32'(bus.din_bus), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_lane = '0;
    bus.wr_addr = '0; bus.wr_data = 8'd0; bus.start = 1'b0;
    for (int i = 0; i < N; i++) acc[i] = 8'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst clear", 32'(bus.clear), 32'd0);
    chk("rst din", 32'(bus.din_bus), 32'd0);
    chk("rst win", 32'(bus.win_bus), 32'd0);
    rst = 1'b1;
    tick();

    // Directed contents: basic, wrap and skew lanes.
    for (int j = 0; j < K; j++) begin
      wr(1'b0, 0, j, 8'd1);
      wr(1'b1, 0, j, 8'(j + 1));
      wr(1'b0, 1, j, 8'd20);
      wr(1'b1, 1, j, 8'd20);
      wr(1'b0, 2, j, 8'(j + 5));
      wr(1'b1, 2, j, 8'(j + 5));
    end
    wr(1'b0, 3, 0, 8'hAA);   // lane out of range, dropped
    wr(1'b1, 3, 4, 8'hBB);

    // Pass with a stray start in cycle 5 and a dropped write in STREAM.
    run_pass(5, 7, 1'b0);
    chk("basic pe0", 32'(acc[0]), 32'd45);
    chk("wrap pe1", 32'(acc[1]), 32'd16);
    chk("skew pe2", 32'(acc[2]), 32'd21);

    // Back-to-back pass: old lane0 value still streamed, no accumulator carry.
    run_pass(0, 0, 1'b0);
    chk("b2b pe0", 32'(acc[0]), 32'd45);

    // Randomized contents and passes.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < K; j++) begin
          wr(1'b0, i, j, 8'($urandom));
          wr(1'b1, i, j, 8'($urandom));
        end
      end
      repeat ($urandom_range(2)) tick();
      run_pass(int'($urandom_range(2, P - 1)), int'($urandom_range(2, P - 1)), 1'($urandom_range(1)));
      run_pass(0, 0, 1'b1);
    end

    // Reset in cycle 6 of a pass: outputs clear at once, no done follows.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("mid rst busy", 32'(bus.busy), 32'd0);
    chk("mid rst clear", 32'(bus.clear), 32'd0);
    chk("mid rst done", 32'(bus.done), 32'd0);
    chk("mid rst din", 32'(bus.din_bus), 32'd0);
    chk("mid rst win", 32'(bus.win_bus), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < P; c++) begin
      tick();
      chk($sformatf("post rst done c%0d", c), 32'(bus.done), 32'd0);
      chk($sformatf("post rst busy c%0d", c), 32'(bus.busy), 32'd0);
    end
    run_pass(0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sa_skew_feeder.md
# sa_skew_feeder

Operand sequencer that sits directly upstream of a row of N systolic processing elements. Holds one data vector and one weight vector of length K per lane and streams them into the PE lane inputs with a one-cycle-per-lane diagonal skew. Pulses `clear` to zero the PE accumulators before each pass, and signals `done` once every lane's accumulator holds its final dot product. Arithmetic is unsigned 8-bit throughout, matching the PE datapath.

## Interface
- `N`, default 3: number of PE lanes.
- `K`, default 9: vector length, i.e. MAC terms per output (3x3 kernel).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `wr_en` input 1: buffer write strobe.
- `wr_sel` input 1: buffer select; 0 = data buffer, 1 = weight buffer.
- `wr_lane` input max(1,$clog2(N)): lane index.
- `wr_addr` input max(1,$clog2(K)): element index within the vector.
- `wr_data` input 8: unsigned operand.
- `start` input 1: begin a pass; single-cycle strobe.
- `busy` output 1: high from the cycle after `start` is accepted through the done cycle.
- `done` output 1: one-cycle pulse; PE results are valid.
- `clear` output 1: accumulator clear to all PEs.
- `din_bus` output 8N: lane i data on bits [8i+7:8i].
- `win_bus` output 8N: lane i weight on bits [8i+7:8i].

## Operation
- Storage: per lane, `dmem[i][0..K-1]` and `wmem[i][0..K-1]`, 8-bit each. Storage is not reset; its contents are undefined until written.
- Writes are accepted only in IDLE. A write with `wr_lane>=N` or `wr_addr>=K` is dropped. Writes while `busy` are dropped.
- Registered FSM: IDLE → CLEAR → STREAM → DRAIN → IDLE.
  - IDLE: `busy=0`, buses are 0. If `start=1`, the next state is CLEAR. A write in the same cycle as `start` takes effect and is used by that pass.
  - CLEAR: lasts 1 cycle. `clear=1` and buses are 0. Load `cnt=0` and go to STREAM.
  - STREAM: `cnt` runs from 0 to K+N-2. Lane i drives `dmem[i][cnt-i]` and `wmem[i][cnt-i]` when 0 ≤ cnt-i < K, and 0 otherwise. After `cnt==K+N-2`, go to DRAIN.
  - DRAIN: lasts 1 cycle. `done=1`, buses are 0, `clear=0`. Go to IDLE.
- `start` is ignored in any state other than IDLE.
- `cnt` width is $clog2(K+N). There is no wrap-around within a pass.
- Each product is 8x8 truncated to 8 bits, and PE accumulation wraps mod 256. The feeder itself does no arithmetic on operands.

## Timing
- Reset (`rst=0`, any time, including mid-pass):
  - State goes to IDLE immediately.
  - `busy`, `done` and `clear` go to 0; `din_bus` and `win_bus` go to 0; `cnt` goes to 0.
  - Any pass in progress is abandoned with no `done`.
- All outputs are registered and decoded from state and `cnt`; there are no combinational paths from inputs.
- Relative to the cycle where `start` is sampled (cycle 0):
  - cycle 1: CLEAR, `clear=1`, `busy=1`.
  - cycles 2 to K+N: STREAM.
  - cycle K+N+1: DRAIN, `done=1`.
  - cycle K+N+2: IDLE, `busy=0`. The earliest next `start` is sampled here.
- Lane i receives element j in cycle 2+i+j. Lane 0 is first: element 0 in cycle 2. Lane N-1 is last: element K-1 in cycle K+N.
- PE accumulators capture the last product at the edge that ends cycle K+N, so PE outputs are final during the `done` cycle.
- Pass period is K+N+2 cycles, which is 14 for the defaults.

## Test plan
- Basic dot product (defaults): lane 0 data all 1, weights 1..9; `start` at cycle 0 → `clear` in cycle 1, `done` in cycle 13 only, PE0 out = 45.
- Skew: lane 2 data = weights = 5,6,7,...,13 → `din_bus[23:16]` is 0 in cycles 2–3, 5..13 in cycles 4–12, and 0 in cycle 13. Lane 0 data is nonzero exactly in cycles 2–10.
- Wrap: lane 1 data = weights = 20 for all nine elements → each product is 144 (400 mod 256), PE1 out = 16.
- Ignored events:
  - `start` pulsed in cycle 5 of a pass → no second CLEAR, `done` still only in cycle 13.
  - A write of 99 to lane 0, addr 0 during STREAM is dropped; the next pass still streams the old value.
  - A write to lane 3 is dropped.
- Reset mid-pass: `rst` low during cycle 6 → all outputs 0 immediately, no `done`. A fresh `start` after reset completes in K+N+1 cycles with the correct result.
- Back-to-back passes: `start` in the first IDLE cycle after `done` → second `clear` one cycle later. The second result is independent of the first, with no carry-over in the accumulators.
